// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a zero register, a write-to-read
// bypass, registered read data and an optional pending-write scoreboard.
// Optional feature macro: REGFILE_SCOREBOARD_EN (per-register busy bits, o_rd_busy).
// Without the macro, o_rd_busy is tied low and the issue port is ignored.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [XLEN-1:0]     i_wr_data,
    input  logic                i_rd_en,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic                o_rd_valid,
    input  logic                i_iss_en,
    input  logic [AW-1:0]       i_iss_addr,
    output logic [NRD-1:0]      o_rd_busy
);

    // Out-of-range register numbers alias onto the zero register.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
        return (int'(a) >= NREGS) ? '0 : a;
    endfunction

    logic [XLEN-1:0]     mem_q [NREGS];
    logic [AW-1:0]       wa;
    logic                wr_live;
    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [AW-1:0]       ra;

    // A write takes effect only outside reset and never to register 0.
    assign wa      = map_addr(i_wr_addr);
    assign wr_live = i_rst_n & i_wr_en & (wa != '0);

    // Register array write; contents are deliberately left unreset so it maps to RAM.
    always_ff @(posedge i_clk) begin
        if (wr_live) begin
            mem_q[wa] <= i_wr_data;
        end
    end

    // Read data next-state: zero register, same-cycle write bypass, else array.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ra         = '0;
        if (i_rd_en) begin
            rd_valid_d = 1'b1;
            for (int k = 0; k < NRD; k++) begin
                ra = map_addr(i_rd_addr[k*AW +: AW]);
                if (ra == '0) begin
                    rd_data_d[k*XLEN +: XLEN] = '0;
                end else if (wr_live && (wa == ra)) begin
                    rd_data_d[k*XLEN +: XLEN] = i_wr_data;
                end else begin
                    rd_data_d[k*XLEN +: XLEN] = mem_q[ra];
                end
            end
        end
    end

    // Read output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NRD-1:0]   rd_busy_q, rd_busy_d;
    logic [AW-1:0]    ia;
    logic [AW-1:0]    rb;

    assign ia = map_addr(i_iss_addr);

    // Busy bits: write clears, issue sets; issue is applied last so it wins a tie.
    always_comb begin
        busy_d = busy_q;
        if (wr_live) begin
            busy_d[wa] = 1'b0;
        end
        if (i_iss_en && (ia != '0)) begin
            busy_d[ia] = 1'b1;
        end
    end

    // Per-port busy snapshot; a write landing this cycle already resolves the hazard.
    always_comb begin
        rd_busy_d = rd_busy_q;
        rb        = '0;
        if (i_rd_en) begin
            for (int k = 0; k < NRD; k++) begin
                rb           = map_addr(i_rd_addr[k*AW +: AW]);
                rd_busy_d[k] = busy_q[rb] & ~(wr_live && (wa == rb));
            end
        end
    end

    // Scoreboard state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign o_rd_busy = rd_busy_q;
`else
    logic unused_iss;
    assign unused_iss = ^{i_iss_en, i_iss_addr};
    assign o_rd_busy  = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (XLEN=32, NREGS=24, NRD=3).
// Busy expectations depend on whether REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int NRD   = 3;
    localparam int AW    = 5;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_wr_en;
    logic [AW-1:0]       i_wr_addr;
    logic [XLEN-1:0]     i_wr_data;
    logic                i_rd_en;
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic                o_rd_valid;
    logic                i_iss_en;
    logic [AW-1:0]       i_iss_addr;
    logic [NRD-1:0]      o_rd_busy;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_iss_en   (i_iss_en),
        .i_iss_addr (i_iss_addr),
        .o_rd_busy  (o_rd_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_wr_en    = 1'b0;
        i_wr_addr  = '0;
        i_wr_data  = '0;
        i_rd_en    = 1'b0;
        i_iss_en   = 1'b0;
        i_iss_addr = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        i_rd_en   = 1'b1;
        i_rd_addr = {a2, a1, a0};
    endtask

    task automatic iss(input logic [AW-1:0] a);
        i_iss_en   = 1'b1;
        i_iss_addr = a;
    endtask

    function automatic logic [2:0] sb(input logic [2:0] v);
`ifdef REGFILE_SCOREBOARD_EN
        return v;
`else
        return 3'b000;
`endif
    endfunction

    initial begin
        idle();
        i_rd_addr = '0;
        i_rst_n   = 1'b0;
        step();
        chk("reset_data", 96'(o_rd_data), 96'h0);
        chk("reset_valid", 96'(o_rd_valid), 96'h0);
        chk("reset_busy", 96'(o_rd_busy), 96'h0);
        i_rst_n = 1'b1;

        // write x5, then read ports {5,0,0}
        idle(); wr(5, 32'hDEADBEEF); step();
        chk("no_read_valid", 96'(o_rd_valid), 96'h0);
        idle(); rd(5, 0, 0); step();
        chk("read_x5_data", 96'(o_rd_data), {32'h0, 32'h0, 32'hDEADBEEF});
        chk("read_x5_valid", 96'(o_rd_valid), 96'h1);

        // bypass on port1
        idle(); wr(7, 32'h12345678); rd(5, 7, 0); step();
        chk("bypass_x7", 96'(o_rd_data), {32'h0, 32'h12345678, 32'hDEADBEEF});

        // x0 write ignored; idle cycle holds data
        idle(); wr(0, 32'hFFFFFFFF); step();
        chk("idle_hold_data", 96'(o_rd_data), {32'h0, 32'h12345678, 32'hDEADBEEF});
        chk("idle_valid", 96'(o_rd_valid), 96'h0);
        idle(); wr(0, 32'hFFFFFFFF); rd(0, 7, 0); step();
        chk("read_x0", 96'(o_rd_data), {32'h0, 32'h12345678, 32'h0});
        chk("read_x0_valid", 96'(o_rd_valid), 96'h1);
        idle(); step();
        chk("hold_after_x0", 96'(o_rd_data), {32'h0, 32'h12345678, 32'h0});
        chk("hold_valid", 96'(o_rd_valid), 96'h0);

        // out-of-range addresses alias to x0
        idle(); wr(1, 32'd1); step();
        idle(); wr(23, 32'd23); step();
        idle(); wr(25, 32'hAAAA); step();
        idle(); wr(24, 32'h5555); rd(25, 1, 23); step();
        chk("oor_read_25_1_23", 96'(o_rd_data), {32'd23, 32'd1, 32'h0});
        idle(); rd(24, 24, 1); step();
        chk("oor_read_24", 96'(o_rd_data), {32'd1, 32'h0, 32'h0});

        // scoreboard
        idle(); iss(3); step();
        idle(); rd(3, 4, 0); step();
        chk("busy_after_issue", 96'(o_rd_busy), 96'(sb(3'b001)));
        idle(); wr(3, 32'h33); rd(3, 4, 0); step();
        chk("busy_cleared_by_write", 96'(o_rd_busy), 96'(sb(3'b000)));
        chk("bypass_x3", 96'(o_rd_data), {32'h0, 32'h0, 32'h33});
        idle(); iss(3); wr(3, 32'h44); step();
        idle(); iss(4); rd(3, 4, 0); step();
        chk("issue_wins_tie", 96'(o_rd_busy), 96'(sb(3'b001)));
        chk("read_x3_after_tie", 96'(o_rd_data), {32'h0, 32'h0, 32'h44});
        idle(); rd(3, 4, 0); step();
        chk("busy_x4_visible", 96'(o_rd_busy), 96'(sb(3'b011)));

        // reset clears busy, discards write/issue, keeps array contents
        idle(); wr(9, 32'h99999999); step();
        idle(); iss(9); step();
        idle(); rd(0, 0, 9); step();
        chk("busy_x9", 96'(o_rd_busy), 96'(sb(3'b100)));
        idle(); i_rst_n = 1'b0; wr(9, 32'h00000BAD); iss(9); rd(0, 0, 9); step();
        chk("midreset_data", 96'(o_rd_data), 96'h0);
        chk("midreset_valid", 96'(o_rd_valid), 96'h0);
        chk("midreset_busy", 96'(o_rd_busy), 96'h0);
        i_rst_n = 1'b1;
        idle(); rd(0, 0, 9); step();
        chk("post_reset_x9", 96'(o_rd_data), {32'h99999999, 32'h0, 32'h0});
        chk("post_reset_valid", 96'(o_rd_valid), 96'h1);
        chk("post_reset_busy", 96'(o_rd_busy), 96'h0);

        idle(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
